// File: rtl/pipelined_shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_pkg
//  Description : Shared definitions for the pipelined barrel shifter: shift
//                mode encodings, a constant-evaluable clog2, and the layout
//                of the per-stage payload word.
//  Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    localparam int MODE_BITS = 3;

    localparam logic [MODE_BITS-1:0] MODE_SRA  = 3'b000;
    localparam logic [MODE_BITS-1:0] MODE_SRL  = 3'b001;
    localparam logic [MODE_BITS-1:0] MODE_SLL  = 3'b010;
    localparam logic [MODE_BITS-1:0] MODE_SLL2 = 3'b011;
    localparam logic [MODE_BITS-1:0] MODE_ROR  = 3'b100;
    localparam logic [MODE_BITS-1:0] MODE_ROL  = 3'b101;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Payload word, MSB to LSB: {valid, mode, amt, data, carry}.
    // The carry bit is resolved from the original operand before the first
    // mux level, so it only has to ride along with the data afterwards.
    function automatic int payload_bits(input int width);
        return 1 + MODE_BITS + clog2(width) + width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_shifter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_shifter_if
//  Description : Operation/result handshake bundle of the pipelined shifter.
//                slave  : shifter side (takes operations, drives results)
//                master : producer/consumer side
//  Ports       : in_valid/in_ready/in_mode/in_a/in_b   operation channel
//                out_valid/out_ready/out_result/flags  result channel
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_shifter_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_mode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_carry;
    logic             out_neg;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_mode, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry, out_neg, out_ovf
    );

    modport master (
        output in_valid, in_mode, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry, out_neg, out_ovf
    );

endinterface
`default_nettype wire

// File: rtl/pipelined_shifter_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_stage
//  Description : One register slice of the barrel shifter. Applies mux levels
//                LO..HI (level k shifts/rotates by 2**k when amt[k] is set)
//                to the incoming payload and registers the result.
//  Ports       : clk    clock
//                rst    synchronous clear of the slice (valid and data)
//                hold   keep the current contents (pipeline stall)
//                d_in   payload from the previous slice
//                q_out  registered payload to the next slice
//  Revision    : 1.0 - initial release
// ============================================================================
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LO    = 0,
    parameter int HI    = 0
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        hold,
    input  wire logic [payload_bits(WIDTH)-1:0] d_in,
    output logic      [payload_bits(WIDTH)-1:0] q_out
);

    localparam int SHW = clog2(WIDTH);

    typedef struct packed {
        logic                 valid;
        logic [MODE_BITS-1:0] mode;
        logic [SHW-1:0]       amt;
        logic [WIDTH-1:0]     data;
        logic                 carry;
    } payload_t;

    payload_t         w_in;
    payload_t         w_next;
    payload_t         r_q;
    logic [WIDTH-1:0] w_lvl [LO:HI+1];

    // Single mux level. Arithmetic right shifts keep filling with the top
    // bit, which is still the original sign bit at every level.
    function automatic logic [WIDTH-1:0] apply_level(
        input logic [WIDTH-1:0]     data,
        input logic [MODE_BITS-1:0] mode,
        input int                   level
    );
        int step;
        step = 1 << level;
        case (mode)
            MODE_SRA:            apply_level = $signed(data) >>> step;
            MODE_SRL:            apply_level = data >> step;
            MODE_SLL, MODE_SLL2: apply_level = data << step;
            MODE_ROR:            apply_level = (data >> step) | (data << (WIDTH - step));
            MODE_ROL:            apply_level = (data << step) | (data >> (WIDTH - step));
            default:             apply_level = data;
        endcase
    endfunction

    assign w_in     = d_in;
    assign w_lvl[LO] = w_in.data;

    for (genvar k = LO; k <= HI; k++) begin : g_level
        assign w_lvl[k+1] = w_in.amt[k] ? apply_level(w_lvl[k], w_in.mode, k) : w_lvl[k];
    end

    always_comb begin
        w_next      = w_in;
        w_next.data = w_lvl[HI+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (!hold) begin
            r_q <= w_next;
        end
    end

    assign q_out = r_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_shifter
//  Description : Parametrised pipelined barrel shifter (SRA/SRL/SLL/ROR/ROL)
//                with valid/ready handshake, global stall and Z/C/N/V flags.
//                Operand A gives the shift amount, B gives the data.
//  Ports       : clk, rst  clock and synchronous active-high reset
//                bus       pipelined_shifter_if.slave (operation in, result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input wire logic             clk,
    input wire logic             rst,
    pipelined_shifter_if.slave   bus
);

    localparam int SHW = clog2(WIDTH);
    localparam int PW  = payload_bits(WIDTH);
    localparam int PER = SHW / STAGES;

    logic             w_advance;
    logic             w_hold;
    logic [SHW-1:0]   w_amt;
    logic [SHW-1:0]   w_amt_m1;
    logic [SHW-1:0]   w_amt_neg;
    logic             w_right;
    logic             w_left;
    logic             w_carry;
    logic [PW-1:0]    w_pipe [0:STAGES];
    logic [PW-1:0]    w_out;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_out_data;
    logic             w_unused_fields;

    // Global stall: every slice moves together, or none does.
    assign w_advance = ~w_out_valid | bus.out_ready;
    assign w_hold    = ~w_advance;

    assign w_amt     = bus.in_a[SHW-1:0];
    assign w_amt_m1  = w_amt - SHW'(1);
    assign w_amt_neg = SHW'(0) - w_amt;   // WIDTH - n, modulo WIDTH

    // The carry is the last bit to leave B. For the rotates this equals the
    // bit that wraps around to result[WIDTH-1] (ROR) or result[0] (ROL), so
    // it can be taken from B up front just like the shifts.
    always_comb begin
        w_right = (bus.in_mode == MODE_SRA) || (bus.in_mode == MODE_SRL) ||
                  (bus.in_mode == MODE_ROR);
        w_left  = (bus.in_mode == MODE_SLL) || (bus.in_mode == MODE_SLL2) ||
                  (bus.in_mode == MODE_ROL);
        w_carry = 1'b0;
        if (w_amt != '0) begin
            if (w_right) begin
                w_carry = bus.in_b[w_amt_m1];
            end else if (w_left) begin
                w_carry = bus.in_b[w_amt_neg];
            end
        end
    end

    // Stage 0 holds while stalled, so in_valid only matters when advancing.
    assign w_pipe[0] = {bus.in_valid & ~rst, bus.in_mode, w_amt, bus.in_b, w_carry};

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * PER;
        localparam int HI = (s == STAGES - 1) ? (SHW - 1) : (LO + PER - 1);

        shifter_stage #(
            .WIDTH (WIDTH),
            .LO    (LO),
            .HI    (HI)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .hold  (w_hold),
            .d_in  (w_pipe[s]),
            .q_out (w_pipe[s+1])
        );
    end

    assign w_out       = w_pipe[STAGES];
    assign w_out_valid = w_out[PW-1];
    assign w_out_data  = w_out[WIDTH:1];

    // Mode/amount are not needed past the last mux level; only the low SHW
    // bits of A select the amount.
    assign w_unused_fields = ^{w_out[PW-2:WIDTH+1], bus.in_a[WIDTH-1:SHW]};

    assign bus.in_ready   = w_advance;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = w_out_data;
    assign bus.out_carry  = w_out[0];
    // Zero is qualified by valid so an empty/reset pipeline reports 0.
    assign bus.out_zero   = w_out_valid & ~|w_out_data;
    assign bus.out_neg    = w_out_data[WIDTH-1];
    assign bus.out_ovf    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_shifter
//  Description : Self-checking bench for pipelined_shifter (WIDTH=32,
//                STAGES=2): directed vector table, back-pressure, reset
//                mid-flight and a random sweep against a bit-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_shifter;
    import shifter_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic clk = 1'b0;
    logic rst;

    pipelined_shifter_if #(.WIDTH(WIDTH)) bus ();

    pipelined_shifter #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        n;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Bit-by-bit reference: returns {carry, result}.
    function automatic logic [32:0] model(input logic [2:0] mode, input logic [31:0] a,
                                          input logic [31:0] b);
        int          n;
        logic [31:0] r;
        logic        c;
        n = int'(a[4:0]);
        r = b;
        c = 1'b0;
        if (n != 0) begin
            case (mode)
                3'd0, 3'd1: begin
                    for (int i = 0; i < 32; i++) begin
                        if (i + n < 32) r[i] = b[i+n];
                        else            r[i] = (mode == 3'd0) ? b[31] : 1'b0;
                    end
                    c = b[n-1];
                end
                3'd2, 3'd3: begin
                    for (int i = 0; i < 32; i++) begin
                        if (i >= n) r[i] = b[i-n];
                        else        r[i] = 1'b0;
                    end
                    c = b[32-n];
                end
                3'd4: begin
                    for (int i = 0; i < 32; i++) r[i] = b[(i + n) % 32];
                    c = r[31];
                end
                3'd5: begin
                    for (int i = 0; i < 32; i++) r[i] = b[(i - n + 32) % 32];
                    c = r[0];
                end
                default: begin
                    r = b;
                    c = 1'b0;
                end
            endcase
        end
        return {c, r};
    endfunction

    function automatic vec_t mk(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic z, input logic c, input logic n);
        vec_t v;
        v.mode = mode; v.a = a; v.b = b; v.res = res; v.z = z; v.c = c; v.n = n;
        return v;
    endfunction

    // Called at posedge+1 with an empty pipeline; one op, out_ready high.
    task automatic run_vec(input vec_t v, input int idx);
        int    lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        bus.in_mode   = v.mode;
        bus.in_a      = v.a;
        bus.in_b      = v.b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, STAGES);
        check({tag, " result"}, bus.out_result, v.res);
        check({tag, " zero"},  bus.out_zero,  v.z);
        check({tag, " carry"}, bus.out_carry, v.c);
        check({tag, " neg"},   bus.out_neg,   v.n);
        check({tag, " ovf"},   bus.out_ovf,   1'b0);
        @(posedge clk); #1;
        check({tag, " drained"}, bus.out_valid, 1'b0);
    endtask

    logic [32:0] bp_exp [3];
    logic [32:0] exp_q [$];
    logic [32:0] cur;

    initial begin
        int got, first, last, stale, issued, cyc;
        logic stall_prev, acc;
        logic [31:0] held_res;

        // Hand-computed directed vectors (WIDTH=32).
        vecs.push_back(mk(MODE_SRA,  32'd4,  32'h8000_0010, 32'hF800_0001, 0, 0, 1));
        vecs.push_back(mk(MODE_SRL,  32'd4,  32'h0000_000F, 32'h0000_0000, 1, 1, 0));
        vecs.push_back(mk(MODE_SLL,  32'd1,  32'h8000_0001, 32'h0000_0002, 0, 1, 0));
        vecs.push_back(mk(MODE_ROR,  32'd1,  32'h0000_0001, 32'h8000_0000, 0, 1, 1));
        vecs.push_back(mk(MODE_ROL,  32'd33, 32'h8000_0000, 32'h0000_0001, 0, 1, 0));
        vecs.push_back(mk(MODE_SRA,  32'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1));
        vecs.push_back(mk(MODE_SRL,  32'd32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1));
        vecs.push_back(mk(MODE_SLL,  32'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1));
        vecs.push_back(mk(MODE_SLL2, 32'd64, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1));
        vecs.push_back(mk(MODE_ROR,  32'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1));
        vecs.push_back(mk(MODE_ROL,  32'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1));
        vecs.push_back(mk(3'd6,      32'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1));
        vecs.push_back(mk(MODE_SLL2, 32'd31, 32'h0000_0001, 32'h8000_0000, 0, 0, 1));
        vecs.push_back(mk(MODE_SRA,  32'd31, 32'h7FFF_FFFF, 32'h0000_0000, 1, 1, 0));
        vecs.push_back(mk(MODE_SRA,  32'd31, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1));
        vecs.push_back(mk(3'd7,      32'd5,  32'h0000_0000, 32'h0000_0000, 1, 0, 0));
        vecs.push_back(mk(3'd6,      32'd9,  32'h1234_5678, 32'h1234_5678, 0, 0, 0));
        vecs.push_back(mk(MODE_ROL,  32'd4,  32'h1234_5678, 32'h2345_6781, 0, 1, 0));
        vecs.push_back(mk(MODE_ROR,  32'd8,  32'h1234_5678, 32'h7812_3456, 0, 0, 0));

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 3'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid",  bus.out_valid,  1'b0);
        check("reset out_result", bus.out_result, 32'h0);
        check("reset out_zero",   bus.out_zero,   1'b0);
        check("reset out_carry",  bus.out_carry,  1'b0);
        check("reset out_neg",    bus.out_neg,    1'b0);
        check("reset out_ovf",    bus.out_ovf,    1'b0);
        check("reset in_ready",   bus.in_ready,   1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // ---------------- back-pressure ----------------
        bus.out_ready = 1'b0;
        bp_exp[0] = model(MODE_SRL, 32'd8, 32'hFF00_FF00);
        bp_exp[1] = model(MODE_SLL, 32'd4, 32'h0000_000F);
        bp_exp[2] = model(MODE_ROL, 32'd8, 32'h1234_5678);
        bus.in_mode = MODE_SRL; bus.in_a = 32'd8; bus.in_b = 32'hFF00_FF00; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_mode = MODE_SLL; bus.in_a = 32'd4; bus.in_b = 32'h0000_000F;
        @(posedge clk); #1;
        bus.in_mode = MODE_ROL; bus.in_a = 32'd8; bus.in_b = 32'h1234_5678;
        check("bp out_valid", bus.out_valid, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("bp in_ready low", bus.in_ready, 1'b0);
            check("bp hold result", bus.out_result, bp_exp[0][31:0]);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (got < 3) begin
                    check($sformatf("bp result%0d", got), bus.out_result, bp_exp[got][31:0]);
                    check($sformatf("bp carry%0d", got), bus.out_carry, bp_exp[got][32]);
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            @(posedge clk); #1;
            if (c == 0) bus.in_valid = 1'b0;
        end
        check("bp result count", got, 3);
        check("bp back-to-back", last - first, 2);

        // ---------------- reset mid-flight ----------------
        bus.in_mode = MODE_SLL; bus.in_a = 32'd3; bus.in_b = 32'h0000_0011; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_mode = MODE_SRL; bus.in_a = 32'd2; bus.in_b = 32'h0000_0100;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_mode = MODE_ROR; bus.in_a = 32'd1; bus.in_b = 32'h0000_0003;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("rst flush out_valid", bus.out_valid, 1'b0);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) stale++;
            @(posedge clk); #1;
        end
        check("rst no stale result", stale, 0);
        run_vec(vecs[0], 100);

        // ---------------- random sweep ----------------
        issued = 0; cyc = 0; stall_prev = 1'b0; held_res = '0;
        while ((issued < 60 || exp_q.size() > 0) && cyc < 3000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (issued < 60 && !bus.in_valid) begin
                bus.in_mode = 3'($urandom_range(0, 7));
                bus.in_a    = $urandom;
                case ($urandom_range(0, 3))
                    0:       bus.in_b = 32'h8000_0000 | $urandom;
                    1:       bus.in_b = 32'h0000_0001 << $urandom_range(0, 31);
                    default: bus.in_b = $urandom;
                endcase
                bus.in_valid = 1'b1;
            end
            @(negedge clk);
            if (stall_prev) check("sweep hold", bus.out_result, held_res);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sweep unexpected result", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("sweep result", bus.out_result, cur[31:0]);
                    check("sweep carry",  bus.out_carry,  cur[32]);
                    check("sweep zero",   bus.out_zero,   (cur[31:0] == 32'h0));
                    check("sweep neg",    bus.out_neg,    cur[31]);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held_res   = bus.out_result;
            acc        = bus.in_valid && bus.in_ready;
            if (acc) begin
                exp_q.push_back(model(bus.in_mode, bus.in_a, bus.in_b));
                issued++;
            end
            @(posedge clk); #1;
            if (acc) bus.in_valid = 1'b0;
            cyc++;
        end
        check("sweep issued", issued, 60);
        check("sweep drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
